// File: rtl/i2c_target_responder.sv
// Single-address I2C target: START/STOP detect, 7-bit address match, byte sink/source handshake.
// Optional SCL/SDA glitch filter is enabled with `define I2C_TGT_GLITCH_FILT_EN.
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h44,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  input  logic       wr_full_i,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  input  logic       rd_valid_i,
  output logic       rd_underrun_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       rw_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic w_scl, w_sda;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
    end

`ifdef I2C_TGT_GLITCH_FILT_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0]         w_raw, r_lvl;
  logic [1:0][CW-1:0] r_fcnt;
  assign w_raw = {r_scl_sync[SYNC_STAGES-1], r_sda_sync[SYNC_STAGES-1]};

  // A level only moves after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_lvl  <= '1;
      r_fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_raw[i] == r_lvl[i]) r_fcnt[i] <= '0;
        else if (r_fcnt[i] == CW'(FILT_LEN - 1)) begin
          r_lvl[i]  <= w_raw[i];
          r_fcnt[i] <= '0;
        end else r_fcnt[i] <= r_fcnt[i] + 1'b1;
      end
    end
  assign w_scl = r_lvl[1];
  assign w_sda = r_lvl[0];
`else
  logic w_unused_filt;
  assign w_unused_filt = FILT_LEN[0];
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

  logic r_scl_d, r_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift, r_tx, r_rd_buf;
  logic       r_nack, r_mack, r_pend;
  logic [7:0] w_rd_byte;
  logic       w_und;

  // A byte arriving on the same cycle as the fall still makes it onto the bus.
  assign w_und     = r_pend & ~rd_valid_i;
  assign w_rd_byte = r_pend ? (rd_valid_i ? rd_data_i : 8'hFF) : r_rd_buf;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_scl_d <= 1'b1; r_sda_d <= 1'b1;
      r_state <= S_IDLE; r_cnt <= '0;
      r_shift <= '0; r_tx <= '1; r_rd_buf <= '1;
      r_nack <= 1'b0; r_mack <= 1'b0; r_pend <= 1'b0;
      sda_o <= 1'b1; wr_data_o <= '0; wr_valid_o <= 1'b0;
      rd_req_o <= 1'b0; rd_underrun_o <= 1'b0;
      start_o <= 1'b0; stop_o <= 1'b0; busy_o <= 1'b0; rw_o <= 1'b0;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      wr_valid_o <= 1'b0; rd_req_o <= 1'b0; rd_underrun_o <= 1'b0;
      start_o <= 1'b0; stop_o <= 1'b0;
      if (r_pend && rd_valid_i) begin
        r_pend   <= 1'b0;
        r_rd_buf <= rd_data_i;
      end
      if (w_start) begin
        r_state <= S_ADDR; r_cnt <= '0; sda_o <= 1'b1;
        start_o <= 1'b1; busy_o <= 1'b1; r_pend <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE; r_cnt <= '0; sda_o <= 1'b1;
        stop_o <= 1'b1; busy_o <= 1'b0; r_pend <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR, S_WR_BYTE, S_RD_BYTE: begin
            r_shift <= {r_shift[6:0], w_sda};
            if (r_cnt != 4'd8) r_cnt <= r_cnt + 4'd1;
            if (r_state == S_WR_BYTE && r_cnt == 4'd7) begin
              r_nack <= wr_full_i;
              if (!wr_full_i) begin
                wr_valid_o <= 1'b1;
                wr_data_o  <= {r_shift[6:0], w_sda};
              end
            end
          end
          S_ADDR_ACK: if (rw_o) begin rd_req_o <= 1'b1; r_pend <= 1'b1; end
          S_RD_ACK: begin
            r_mack <= ~w_sda;
            if (!w_sda) begin rd_req_o <= 1'b1; r_pend <= 1'b1; end
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: if (r_cnt == 4'd8) begin
            if (r_shift[7:1] == SLAVE_ADDR) begin
              r_state <= S_ADDR_ACK; sda_o <= 1'b0; rw_o <= r_shift[0];
            end else r_state <= S_IGNORE;
          end
          S_ADDR_ACK, S_RD_ACK: begin
            r_cnt <= '0;
            if ((r_state == S_ADDR_ACK && rw_o) || (r_state == S_RD_ACK && r_mack)) begin
              r_state <= S_RD_BYTE;
              sda_o   <= w_rd_byte[7];
              r_tx    <= {w_rd_byte[6:0], 1'b1};
              r_pend  <= 1'b0;
              rd_underrun_o <= w_und;
            end else begin
              r_state <= (r_state == S_ADDR_ACK) ? S_WR_BYTE : S_IGNORE;
              sda_o   <= 1'b1;
            end
          end
          S_WR_BYTE: if (r_cnt == 4'd8) begin r_state <= S_WR_ACK; sda_o <= r_nack; end
          S_WR_ACK: begin
            r_cnt <= '0; sda_o <= 1'b1;
            r_state <= r_nack ? S_IGNORE : S_WR_BYTE;
          end
          S_RD_BYTE:
            if (r_cnt == 4'd8) begin r_state <= S_RD_ACK; sda_o <= 1'b1; end
            else begin sda_o <= r_tx[7]; r_tx <= {r_tx[6:0], 1'b1}; end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench: bit-banged I2C master plus a transaction-level model of what the target must answer.
module tb_i2c_target_responder;
  localparam int         Q    = 10;
  localparam logic [6:0] ADDR = 7'h44;
  typedef enum {P_IDLE, P_ADDR, P_WR, P_RD, P_IGN} phase_e;

  logic       clk_i = 1'b0, rst_i = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic       wr_full_i = 1'b0, rd_valid_i = 1'b0;
  logic [7:0] rd_data_i = '0;
  logic       sda_o, wr_valid_o, rd_req_o, rd_underrun_o, start_o, stop_o, busy_o, rw_o;
  logic [7:0] wr_data_o;
  logic       scl_i, sda_i;
  assign scl_i = scl_m;
  assign sda_i = sda_m & sda_o;

  i2c_target_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda_o),
    .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .wr_full_i(wr_full_i),
    .rd_req_o(rd_req_o), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
    .rd_underrun_o(rd_underrun_o), .start_o(start_o), .stop_o(stop_o),
    .busy_o(busy_o), .rw_o(rw_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;
  int cnt_wr, cnt_start, cnt_stop, cnt_req, cnt_und, exp_und;
  logic m_quiet = 1'b0, rd_hold = 1'b0;
  phase_e m_phase = P_IDLE;
  logic [7:0] exp_wr[$], exp_rd[$], src_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    cnt_wr = 0; cnt_start = 0; cnt_stop = 0; cnt_req = 0; cnt_und = 0; exp_und = 0;
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk_i) if (rst_i) begin
    if (wr_valid_o) begin
      cnt_wr++;
      if (exp_wr.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL wr_unexpected got %0h want none", wr_data_o);
      end else chk("wr_data", 32'(wr_data_o), 32'(exp_wr.pop_front()));
    end
    if (start_o) cnt_start++;
    if (stop_o) cnt_stop++;
    if (rd_req_o) cnt_req++;
    if (rd_underrun_o) cnt_und++;
    if (m_quiet) chk("sda_released", 32'(sda_o), 32'd1);
  end

  // Local byte source: answers each request two cycles later unless held off.
  initial forever begin
    @(negedge clk_i);
    rd_valid_i = 1'b0;
    if (rd_req_o && !rd_hold && src_q.size() > 0) begin
      repeat (2) @(negedge clk_i);
      rd_data_i  = src_q.pop_front();
      rd_valid_i = 1'b1;
    end
  end

  task automatic qwait(); repeat (Q) @(negedge clk_i); endtask
  task automatic i2c_start();
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
    m_phase = P_ADDR;
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
    m_phase = P_IDLE;
  endtask
  task automatic wbit(input logic b);
    sda_m = b; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
  endtask
  task automatic rbit(output logic v);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); v = sda_i; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic send_byte(input string name, input logic [7:0] b);
    logic ack, exp_ack;
    case (m_phase)
      P_ADDR: begin
        exp_ack = (b[7:1] == ADDR) ? 1'b0 : 1'b1;
        m_phase = (b[7:1] != ADDR) ? P_IGN : (b[0] ? P_RD : P_WR);
      end
      P_WR: begin
        exp_ack = wr_full_i;
        if (!wr_full_i) exp_wr.push_back(b); else m_phase = P_IGN;
      end
      default: exp_ack = 1'b1;
    endcase
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(ack);
    chk(name, 32'(ack), 32'(exp_ack));
  endtask

  task automatic src_push(input logic [7:0] b);
    src_q.push_back(b); exp_rd.push_back(b);
  endtask

  task automatic recv_byte(input string name, input logic mack, output logic [7:0] got);
    logic [7:0] exp_b;
    logic v;
    if (rd_hold || exp_rd.size() == 0) begin exp_b = 8'hFF; exp_und++; end
    else exp_b = exp_rd.pop_front();
    for (int i = 7; i >= 0; i--) begin rbit(v); got[i] = v; end
    chk(name, 32'(got), 32'(exp_b));
    wbit(mack);
    if (mack) m_phase = P_IGN;
  endtask

  initial begin
    logic [7:0] g;
    #5_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] g;
    clr();
    repeat (3) @(negedge clk_i);
    chk("rst_sda", 32'(sda_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rw", 32'(rw_o), 32'd0);
    chk("rst_wrdata", 32'(wr_data_o), 32'd0);
    chk("rst_strobes", 32'({wr_valid_o, rd_req_o, rd_underrun_o, start_o, stop_o}), 32'd0);
    rst_i = 1'b1;
    m_quiet = 1'b1; qwait(); m_quiet = 1'b0;

    // 1: plain write
    clr();
    i2c_start(); send_byte("t1_addr_ack", 8'h88);
    send_byte("t1_d0_ack", 8'hDE); send_byte("t1_d1_ack", 8'hAD);
    i2c_stop(); qwait();
    chk("t1_wr_cnt", 32'(cnt_wr), 32'd2); chk("t1_stop_cnt", 32'(cnt_stop), 32'd1);
    chk("t1_start_cnt", 32'(cnt_start), 32'd1); chk("t1_q_empty", 32'(exp_wr.size()), 32'd0);

    // 2: wrong address
    clr();
    i2c_start(); m_quiet = 1'b1;
    send_byte("t2_addr_nack", 8'h8A); send_byte("t2_d0_nack", 8'h12);
    chk("t2_busy_mid", 32'(busy_o), 32'd1);
    i2c_stop(); qwait();
    chk("t2_busy_end", 32'(busy_o), 32'd0); chk("t2_wr_cnt", 32'(cnt_wr), 32'd0);
    m_quiet = 1'b0;

    // 3: read two bytes, ACK then NACK
    clr();
    src_push(8'hA5); src_push(8'h3C);
    i2c_start(); send_byte("t3_addr_ack", 8'h89);
    recv_byte("t3_b0", 1'b0, g); chk("t3_b0_lit", 32'(g), 32'hA5);
    recv_byte("t3_b1", 1'b1, g); chk("t3_b1_lit", 32'(g), 32'h3C);
    i2c_stop(); qwait();
    chk("t3_req_cnt", 32'(cnt_req), 32'd2); chk("t3_und_cnt", 32'(cnt_und), 32'd0);

    // 4: source never answers
    clr(); rd_hold = 1'b1;
    i2c_start(); send_byte("t4_addr_ack", 8'h89);
    recv_byte("t4_b0", 1'b1, g); chk("t4_b0_lit", 32'(g), 32'hFF);
    i2c_stop(); qwait(); rd_hold = 1'b0;
    chk("t4_und_cnt", 32'(cnt_und), 32'(exp_und)); chk("t4_req_cnt", 32'(cnt_req), 32'd1);

    // 5: write, repeated START, read
    clr(); src_push(8'h96);
    i2c_start(); send_byte("t5_addr_w", 8'h88); chk("t5_rw0", 32'(rw_o), 32'd0);
    send_byte("t5_d0_ack", 8'h55);
    i2c_start(); send_byte("t5_addr_r", 8'h89); chk("t5_rw1", 32'(rw_o), 32'd1);
    recv_byte("t5_b0", 1'b1, g);
    i2c_stop(); qwait();
    chk("t5_start_cnt", 32'(cnt_start), 32'd2); chk("t5_wr_cnt", 32'(cnt_wr), 32'd1);
    chk("t5_req_cnt", 32'(cnt_req), 32'd1);

    // 7: sink full -> NACK, rest of transfer ignored
    clr();
    i2c_start(); send_byte("t7_addr_ack", 8'h88);
    wr_full_i = 1'b1; send_byte("t7_full_nack", 8'hBB);
    wr_full_i = 1'b0; send_byte("t7_ign_nack", 8'hCC);
    i2c_stop(); qwait();
    chk("t7_wr_cnt", 32'(cnt_wr), 32'd0);

    // 6: reset while the target drives the address ACK
    clr();
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(logic'(8'h88 >> i));
    sda_m = 1'b1;
    for (int i = 0; i < 40 && sda_o; i++) @(negedge clk_i);
    chk("t6_ack_drive", 32'(sda_o), 32'd0);
    #2 rst_i = 1'b0;
    #1 chk("t6_rst_sda", 32'(sda_o), 32'd1);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    i2c_stop(); qwait();
    chk("t6_stop_cnt", 32'(cnt_stop), 32'd1);

    // 6b: one-clock SDA glitch while SCL high
    clr();
    sda_m = 1'b0; @(negedge clk_i); sda_m = 1'b1;
    repeat (20) @(negedge clk_i);
`ifdef I2C_TGT_GLITCH_FILT_EN
    chk("t6_glitch_start", 32'(cnt_start), 32'd0); chk("t6_glitch_stop", 32'(cnt_stop), 32'd0);
`else
    chk("t6_glitch_start", 32'(cnt_start), 32'd1); chk("t6_glitch_stop", 32'(cnt_stop), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
